branch_predictor_bht: RTL and testbench
=======================================

Name: branch_predictor_bht

Overview:
- Parametrised successor to the CPU's static BTFNT branch predictor.
- Indexed branch history table (BHT) of saturating counters, one per entry, with a valid bit per entry; an invalid entry falls back to BTFNT.
- Sits between the decode stage, which looks up and supplies the PC offsets, and the execute stage, which resolves the branch, updates the table and flags a mispredict.

Parameters:
- PC_W, 13, fetch PC width.
- OFF_W, 17, branch offset width (two's complement).
- ENTRIES, 64, BHT depth; power of two, at least 2. Index = dec_pc[log2(ENTRIES)-1:0].
- CTR_W, 2, saturating counter width; counter MSB = predict taken.

Ports:
- clk  in  1  clock.
- reset_low  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall; holds the decode-to-execute capture.
- halted  in  1  debug halt; freezes all state.
- flush  in  1  execute redirect; squashes the decode-side capture.
- dec_opcode  in  5  opcode of the instruction in decode. BT=23, BF=24, JAL=25.
- dec_pc  in  PC_W  PC of the instruction in decode.
- dec_offset  in  OFF_W  signed branch/jump offset in decode.
- predicted_offset  out  OFF_W  offset the fetch stage applies this cycle.
- not_predicted_offset  out  OFF_W  offset for recovery on a mispredict.
- dec_pred_taken  out  1  decode-side prediction.
- ex_valid  out  1  a branch is captured in execute.
- ex_pred_taken  out  1  prediction carried with that branch.
- resolve_valid  in  1  execute resolved a BT/BF this cycle.
- resolve_taken  in  1  actual branch outcome.
- mispredict  out  1  = resolve_valid & ex_valid & (resolve_taken != ex_pred_taken); combinational.

Behaviour:
Reset (reset_low=0, asynchronous):
- All valid bits = 0; all counters = 0.
- ex_valid = 0, ex_pred_taken = 0, ex_index = 0.

Lookup (combinational, decode):
- BT/BF, entry valid: dec_pred_taken = ctr[MSB].
- BT/BF, entry invalid: dec_pred_taken = dec_offset[OFF_W-1] (backward taken).
- Predicted taken: predicted_offset = dec_offset, not_predicted_offset = 1.
- Predicted not taken: predicted_offset = 1, not_predicted_offset = dec_offset.
- JAL: predicted_offset = dec_offset, not_predicted_offset = 1, dec_pred_taken = 1; no table access.
- Any other opcode: both offsets = 1, dec_pred_taken = 0.
- Offsets are returned raw; the fetch stage owns the PC arithmetic.

Capture (posedge clk):
- Priority: halted > flush > stall.
- halted: hold everything.
- flush: ex_valid <= 0.
- stall: hold.
- Otherwise: ex_valid <= (opcode is BT or BF); ex_pred_taken <= dec_pred_taken; ex_index <= index.

Update (posedge clk, when resolve_valid & ex_valid & !halted):
- Entry invalid: valid <= 1; ctr <= taken ? 2^(CTR_W-1) : 2^(CTR_W-1)-1 (weak state).
- Entry valid: taken increments, saturating at 2^CTR_W-1; not taken decrements, saturating at 0.
- resolve_valid with ex_valid=0: ignored, mispredict=0.

Boundary conditions:
- Update and lookup to the same index in one cycle: lookup sees the pre-update value; no bypass.
- Update and capture in the same cycle are independent. The update uses the old ex_index.
- Aliasing of PCs onto one entry is permitted; no tags.
- reset_low asserted mid-update: the reset wins immediately and the table returns to all-invalid.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on every qualifying update.
  - stat_mispredicts increments when mispredict=1.
  - Both reset to 0, wrap modulo 2^32, and hold while halted.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then BT with dec_offset=-4 (0x1FFFC) at pc=5 -> dec_pred_taken=1, predicted_offset=0x1FFFC, not_predicted_offset=1. With dec_offset=+8: pred=0, predicted_offset=1, not_predicted_offset=8.
- Loop training at pc=5, offset -4: resolve taken x3, then not taken.
  - Counter goes 2,3,3, then 2; prediction remains taken.
  - The not-taken resolve asserts mispredict=1 in that cycle.
- Forward BF at pc=9, offset +6, resolved taken twice:
  - First resolve: mispredict=1, ctr=2.
  - Next lookup at pc=9: predicted_offset=6.
- JAL offset 0x40 -> predicted_offset=0x40, ex_valid=0 next cycle. flush on the capture edge -> ex_valid=0; a following resolve_valid produces no update and mispredict=0.
- Aliasing: ENTRIES=4; train pc=1 taken to ctr=3; lookup pc=5 -> taken. Separately:
  - halted=1 with resolve_valid=1 -> table unchanged.
  - stall=1 -> ex_* held for 3 cycles.
- BP_STATS_EN defined: 10 resolves with 3 mispredicts -> stat_branches=10, stat_mispredicts=3. reset_low pulse -> both 0 and all entries invalid (BTFNT again).

Source files
------------

// File: rtl/branch_predictor_bht_if.sv
// Decode/execute-side signal bundle for branch_predictor_bht.
// The statistics outputs exist only when BP_STATS_EN is defined.
interface branch_predictor_bht_if #(
    parameter int PC_W  = 13,
    parameter int OFF_W = 17
);
    logic             stall;
    logic             halted;
    logic             flush;
    logic [4:0]       dec_opcode;
    logic [PC_W-1:0]  dec_pc;
    logic [OFF_W-1:0] dec_offset;
    logic [OFF_W-1:0] predicted_offset;
    logic [OFF_W-1:0] not_predicted_offset;
    logic             dec_pred_taken;
    logic             ex_valid;
    logic             ex_pred_taken;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             mispredict;
`ifdef BP_STATS_EN
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispredicts;
`endif

    modport master (
        output stall, halted, flush, dec_opcode, dec_pc, dec_offset,
               resolve_valid, resolve_taken,
        input  predicted_offset, not_predicted_offset, dec_pred_taken,
               ex_valid, ex_pred_taken, mispredict
`ifdef BP_STATS_EN
      , input  stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  stall, halted, flush, dec_opcode, dec_pc, dec_offset,
               resolve_valid, resolve_taken,
        output predicted_offset, not_predicted_offset, dec_pred_taken,
               ex_valid, ex_pred_taken, mispredict
`ifdef BP_STATS_EN
      , output stat_branches, stat_mispredicts
`endif
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters with a BTFNT fallback for invalid entries.
// Define BP_STATS_EN to add the stat_branches / stat_mispredicts counters.
module branch_predictor_bht #(
    parameter int PC_W    = 13,
    parameter int OFF_W   = 17,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2
) (
    input logic                   clk,
    input logic                   reset_low,
    branch_predictor_bht_if.slave bp
);
    localparam int               IDX_W       = $clog2(ENTRIES);
    localparam logic [4:0]       OP_BT       = 5'd23;
    localparam logic [4:0]       OP_BF       = 5'd24;
    localparam logic [4:0]       OP_JAL      = 5'd25;
    localparam logic [OFF_W-1:0] OFF_ONE     = OFF_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(2 ** (CTR_W - 1) - 1);

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][CTR_W-1:0] ctr_q;
    logic                          ex_valid_q, ex_valid_d;
    logic                          ex_pred_taken_q, ex_pred_taken_d;
    logic [IDX_W-1:0]              ex_index_q, ex_index_d;
    logic [IDX_W-1:0]              dec_index;
    logic                          is_cond, is_jal, dec_pred;
    logic                          upd_en, mispredict;
    logic [CTR_W-1:0]              ctr_cur, ctr_upd;
    logic                          unused_pc;

    assign dec_index = bp.dec_pc[IDX_W-1:0];
    assign unused_pc = ^bp.dec_pc;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        is_cond  = (bp.dec_opcode == OP_BT) || (bp.dec_opcode == OP_BF);
        is_jal   = (bp.dec_opcode == OP_JAL);
        dec_pred = 1'b0;
        if (is_jal)
            dec_pred = 1'b1;
        else if (is_cond)
            dec_pred = valid_q[dec_index] ? ctr_q[dec_index][CTR_W-1]
                                          : bp.dec_offset[OFF_W-1];
        bp.predicted_offset     = OFF_ONE;
        bp.not_predicted_offset = OFF_ONE;
        if (is_cond || is_jal) begin
            if (dec_pred) bp.predicted_offset     = bp.dec_offset;
            else          bp.not_predicted_offset = bp.dec_offset;
        end
    end

    assign bp.dec_pred_taken = dec_pred;

    // Capture priority: halted > flush > stall.
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pred_taken_d = ex_pred_taken_q;
        ex_index_d      = ex_index_q;
        if (!bp.halted) begin
            if (bp.flush) begin
                ex_valid_d = 1'b0;
            end else if (!bp.stall) begin
                ex_valid_d      = is_cond;
                ex_pred_taken_d = dec_pred;
                ex_index_d      = dec_index;
            end
        end
    end

    assign upd_en  = bp.resolve_valid & ex_valid_q & ~bp.halted;
    assign ctr_cur = ctr_q[ex_index_q];

    always_comb begin
        ctr_upd = ctr_cur;
        if (!valid_q[ex_index_q])
            ctr_upd = bp.resolve_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        else if (bp.resolve_taken)
            ctr_upd = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_W'(1);
        else
            ctr_upd = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            ex_valid_q      <= 1'b0;
            ex_pred_taken_q <= 1'b0;
            ex_index_q      <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pred_taken_q <= ex_pred_taken_d;
            ex_index_q      <= ex_index_d;
        end
    end

    // NOTE: the table is flops rather than a RAM because every entry must clear on async reset.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            valid_q <= '0;
            ctr_q   <= '0;
        end else if (upd_en) begin
            valid_q[ex_index_q] <= 1'b1;
            ctr_q[ex_index_q]   <= ctr_upd;
        end
    end

    assign mispredict       = bp.resolve_valid & ex_valid_q & (bp.resolve_taken != ex_pred_taken_q);
    assign bp.mispredict    = mispredict;
    assign bp.ex_valid      = ex_valid_q;
    assign bp.ex_pred_taken = ex_pred_taken_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (upd_en)                   stat_branches_q    <= stat_branches_q + 32'd1;
            if (mispredict && !bp.halted) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign bp.stat_branches    = stat_branches_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: directed scenarios plus randomized traffic, scored
// against an integer-table reference model through an expected-response queue.
module tb_branch_predictor_bht;
    localparam int PC_W     = 13;
    localparam int OFF_W    = 17;
    localparam int ENTRIES  = 4;
    localparam int CTR_W    = 2;
    localparam int CTR_TOP  = 2 ** CTR_W - 1;
    localparam int CTR_HALF = 2 ** (CTR_W - 1);
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_BT  = 5'd23;
    localparam logic [4:0] OP_BF  = 5'd24;
    localparam logic [4:0] OP_JAL = 5'd25;

    typedef struct {
        logic             pred;
        logic [OFF_W-1:0] po;
        logic [OFF_W-1:0] npo;
        logic             ex_valid;
        logic             ex_pred;
        logic             misp;
        logic [31:0]      sb;
        logic [31:0]      sm;
    } exp_t;

    logic clk       = 1'b0;
    logic reset_low = 1'b0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    int          mdl_ctr[ENTRIES];
    bit          mdl_valid[ENTRIES];
    bit          mdl_ex_valid, mdl_ex_pred;
    int          mdl_ex_idx;
    int unsigned mdl_branches, mdl_misp;

    branch_predictor_bht_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bp ();

    branch_predictor_bht #(
        .PC_W(PC_W), .OFF_W(OFF_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W)
    ) dut (
        .clk(clk),
        .reset_low(reset_low),
        .bp(bp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, req);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("sb_pred_taken", bp.dec_pred_taken, mon_e.pred);
            check("sb_pred_off", bp.predicted_offset, mon_e.po);
            check("sb_not_pred_off", bp.not_predicted_offset, mon_e.npo);
            check("sb_ex_valid", bp.ex_valid, mon_e.ex_valid);
            check("sb_ex_pred", bp.ex_pred_taken, mon_e.ex_pred);
            check("sb_mispredict", bp.mispredict, mon_e.misp);
`ifdef BP_STATS_EN
            check("sb_stat_branches", bp.stat_branches, mon_e.sb);
            check("sb_stat_mispredicts", bp.stat_mispredicts, mon_e.sm);
`endif
        end
    end

    // One decode/execute cycle: drive, queue the expected response, advance the model.
    task automatic step(input logic [4:0] op, input int pc, input int off,
                        input bit rv = 0, input bit rt = 0, input bit st = 0,
                        input bit hl = 0, input bit fl = 0);
        exp_t e;
        int   idx;
        bit   cond, jal, pred;
        @(posedge clk);
        #1;
        bp.dec_opcode    = op;
        bp.dec_pc        = PC_W'(pc);
        bp.dec_offset    = OFF_W'(off);
        bp.resolve_valid = rv;
        bp.resolve_taken = rt;
        bp.stall         = st;
        bp.halted        = hl;
        bp.flush         = fl;

        idx  = pc % ENTRIES;
        cond = (op == OP_BT) || (op == OP_BF);
        jal  = (op == OP_JAL);
        if (cond) pred = mdl_valid[idx] ? (mdl_ctr[idx] >= CTR_HALF) : (off < 0);
        else      pred = jal;
        e.pred     = pred;
        e.po       = ((cond || jal) && pred)  ? OFF_W'(off) : OFF_W'(1);
        e.npo      = ((cond || jal) && !pred) ? OFF_W'(off) : OFF_W'(1);
        e.ex_valid = mdl_ex_valid;
        e.ex_pred  = mdl_ex_pred;
        e.misp     = rv && mdl_ex_valid && (rt != mdl_ex_pred);
        e.sb       = mdl_branches;
        e.sm       = mdl_misp;
        sb_q.push_back(e);

        if (!hl) begin
            if (rv && mdl_ex_valid) begin
                if (!mdl_valid[mdl_ex_idx]) begin
                    mdl_valid[mdl_ex_idx] = 1'b1;
                    mdl_ctr[mdl_ex_idx]   = rt ? CTR_HALF : CTR_HALF - 1;
                end else if (rt) begin
                    mdl_ctr[mdl_ex_idx] = (mdl_ctr[mdl_ex_idx] < CTR_TOP) ? mdl_ctr[mdl_ex_idx] + 1 : CTR_TOP;
                end else begin
                    mdl_ctr[mdl_ex_idx] = (mdl_ctr[mdl_ex_idx] > 0) ? mdl_ctr[mdl_ex_idx] - 1 : 0;
                end
                mdl_branches++;
            end
            if (e.misp) mdl_misp++;
            if (fl) begin
                mdl_ex_valid = 1'b0;
            end else if (!st) begin
                mdl_ex_valid = cond;
                mdl_ex_pred  = pred;
                mdl_ex_idx   = idx;
            end
        end
        #3;
    endtask

    // Reset asserted mid-cycle with a resolve pending; it must win over the update.
    task automatic do_reset();
        @(negedge clk);
        #1;
        bp.resolve_valid = 1'b1;
        bp.resolve_taken = 1'b0;
        reset_low        = 1'b0;
        #1;
        check("rst_ex_valid", bp.ex_valid, 1'b0);
        check("rst_ex_pred", bp.ex_pred_taken, 1'b0);
        check("rst_mispredict", bp.mispredict, 1'b0);
`ifdef BP_STATS_EN
        check("rst_stat_branches", bp.stat_branches, 32'd0);
        check("rst_stat_mispredicts", bp.stat_mispredicts, 32'd0);
`endif
        for (int i = 0; i < ENTRIES; i++) begin
            mdl_ctr[i]   = 0;
            mdl_valid[i] = 1'b0;
        end
        mdl_ex_valid = 1'b0;
        mdl_ex_pred  = 1'b0;
        mdl_ex_idx   = 0;
        mdl_branches = 0;
        mdl_misp     = 0;
        @(posedge clk);
        #1;
        bp.dec_opcode    = OP_NOP;
        bp.dec_pc        = '0;
        bp.dec_offset    = '0;
        bp.resolve_valid = 1'b0;
        bp.resolve_taken = 1'b0;
        bp.stall         = 1'b0;
        bp.halted        = 1'b0;
        bp.flush         = 1'b0;
        reset_low        = 1'b1;
    endtask

    initial begin
        bit pat[10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        int r_op, r_pc, r_off;
        logic [4:0] op;

        do_reset();

        // BTFNT fallback on an invalid entry.
        step(OP_BT, 5, -4);
        check("btfnt_back_pred", bp.dec_pred_taken, 1'b1);
        check("btfnt_back_po", bp.predicted_offset, 32'h1FFFC);
        check("btfnt_back_npo", bp.not_predicted_offset, 32'h1);
        step(OP_BT, 5, 8);
        check("btfnt_fwd_pred", bp.dec_pred_taken, 1'b0);
        check("btfnt_fwd_po", bp.predicted_offset, 32'h1);
        check("btfnt_fwd_npo", bp.not_predicted_offset, 32'h8);

        // Loop training: counter 2,3,3 then 2 (still taken), then 1 (not taken).
        do_reset();
        step(OP_BT, 5, -4);
        repeat (3) step(OP_BT, 5, -4, 1, 1);
        step(OP_NOP, 0, 0, 1, 0);
        check("loop_mispredict", bp.mispredict, 1'b1);
        step(OP_BT, 5, -4);
        check("loop_still_taken", bp.dec_pred_taken, 1'b1);
        step(OP_NOP, 0, 0, 1, 0);
        step(OP_BT, 5, -4);
        check("loop_now_not_taken", bp.dec_pred_taken, 1'b0);
        check("loop_nt_npo", bp.not_predicted_offset, 32'h1FFFC);

        // Forward BF trained taken.
        do_reset();
        step(OP_BF, 9, 6);
        check("bf_first_npo", bp.not_predicted_offset, 32'h6);
        step(OP_NOP, 0, 0, 1, 1);
        check("bf_first_mispredict", bp.mispredict, 1'b1);
        step(OP_BF, 9, 6);
        check("bf_trained_po", bp.predicted_offset, 32'h6);
        step(OP_NOP, 0, 0, 1, 1);
        check("bf_second_mispredict", bp.mispredict, 1'b0);

        // JAL is never captured; a flushed branch cannot be resolved.
        do_reset();
        step(OP_JAL, 0, 'h40);
        check("jal_po", bp.predicted_offset, 32'h40);
        check("jal_pred", bp.dec_pred_taken, 1'b1);
        step(OP_NOP, 0, 0);
        check("jal_ex_valid", bp.ex_valid, 1'b0);
        step(OP_BT, 5, -4, 0, 0, 0, 0, 1);
        step(OP_NOP, 0, 0, 1, 0);
        check("flush_ex_valid", bp.ex_valid, 1'b0);
        check("flush_mispredict", bp.mispredict, 1'b0);
        step(OP_BT, 5, -4);
        check("flush_no_update", bp.dec_pred_taken, 1'b1);

        // Aliasing: pc=1 and pc=5 share an entry.
        do_reset();
        step(OP_BT, 1, 8);
        step(OP_BT, 1, 8, 1, 1);
        step(OP_NOP, 0, 0, 1, 1);
        step(OP_BT, 5, 8);
        check("alias_pred", bp.dec_pred_taken, 1'b1);

        // Halt freezes the table and the capture; stall holds the capture.
        step(OP_BT, 2, 8);
        step(OP_BT, 3, 8, 1, 1, 0, 1);
        check("halt_mispredict", bp.mispredict, 1'b1);
        step(OP_BT, 2, 8);
        check("halt_ex_valid", bp.ex_valid, 1'b1);
        check("halt_table_kept", bp.dec_pred_taken, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(OP_JAL, 0, 'h40, 0, 0, 1);
            check("stall_ex_valid", bp.ex_valid, 1'b1);
            check("stall_ex_pred", bp.ex_pred_taken, 1'b0);
        end

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            r_op = int'($urandom_range(0, 9));
            if (r_op < 4)       op = OP_BT;
            else if (r_op < 7)  op = OP_BF;
            else if (r_op == 7) op = OP_JAL;
            else                op = 5'($urandom_range(0, 22));
            r_pc = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                r_off = int'($urandom_range(0, 131071));
                if (r_off >= 65536) r_off -= 131072;
            end else begin
                r_off = int'($urandom_range(0, 64)) - 32;
            end
            step(op, r_pc, r_off, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end

        // Ten resolves with three mispredicts, then a reset during a pending update.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(OP_BT, 0, -4);
            step(OP_NOP, 0, 0, 1, pat[i]);
        end
        step(OP_NOP, 0, 0);
`ifdef BP_STATS_EN
        check("stats_branches", bp.stat_branches, 32'd10);
        check("stats_mispredicts", bp.stat_mispredicts, 32'd3);
`endif
        step(OP_BT, 0, -4);
        check("pre_reset_pred", bp.dec_pred_taken, 1'b1);
        do_reset();
        step(OP_BT, 0, 8);
        check("post_reset_btfnt", bp.dec_pred_taken, 1'b0);
        check("post_reset_npo", bp.not_predicted_offset, 32'h8);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
